event_frame_buffer: RTL and testbench
=====================================

EVENT_FRAME_BUFFER -- requirements
Module: event_frame_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning frame FIFO depth; power of two, 2..16.
REQ-002 The block SHALL have parameter HEADER, default 8'hA5, meaning the valid-frame marker byte.
REQ-003 The block SHALL have parameter IDLE_HEADER, default 8'h5A, meaning the empty-buffer marker byte.
REQ-004 The block SHALL have port sampling_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-006 The block SHALL have port trig_valid  in  1  one-cycle trigger strobe; one event per high cycle.
REQ-007 The block SHALL have port hits  in  64  channel hit pattern, sampled when trig_valid=1.
REQ-008 The block SHALL have port sample_done  in  1  one-cycle pulse from the SPI readout stage at readout end (CS rising); pops the head frame.
REQ-009 The block SHALL have port data  out  128  head frame presented to the SPI readout stage.
REQ-010 The block SHALL have port frame_pending  out  1  high when at least one frame is stored; host readout request line.
REQ-011 The block SHALL have port dropped  out  8  saturating count of events lost to a full buffer.

Function
REQ-012 Frame layout SHALL be [127:120] HEADER, [119:112] dropped count at capture, [111:96] event number, [95:64] timestamp, [63:0] hits.
REQ-013 The timestamp SHALL be a free-running 32-bit counter: +1 per cycle, wrapping 0xFFFFFFFF->0; the value at the trig_valid cycle is stored.
REQ-014 The event number SHALL be a 16-bit counter: +1 per accepted or dropped trigger, wrapping 0xFFFF->0; the pre-increment value is stored.
REQ-015 A trigger accepted at cycle N SHALL be visible on data and frame_pending from cycle N+1 if the buffer was empty.
REQ-016 data SHALL change only on a pop, or on the empty->non-empty transition, so that it stays stable for the whole SPI transfer.
REQ-017 When empty, data SHALL equal {IDLE_HEADER, dropped, 16'h0, timestamp of last pop or 0, 64'h0}, and frame_pending SHALL be 0.
REQ-018 sample_done while empty SHALL be ignored: no pointer change and no underflow.
REQ-019 trig_valid while full without a same-cycle sample_done SHALL drop the event: frame not stored, event number still incremented, dropped += 1 saturating at 8'hFF.
REQ-020 Simultaneous trig_valid and sample_done while full SHALL pop the head and store the new frame; no drop; occupancy unchanged.
REQ-021 Simultaneous trig_valid and sample_done while holding exactly one frame SHALL present the new frame on the next cycle, with frame_pending remaining 1.
REQ-022 Occupancy SHALL be tracked with a count of width clog2(DEPTH)+1; read and write pointers SHALL wrap modulo DEPTH.
REQ-023 dropped SHALL clear only on reset.

Reset
REQ-024 On rst=1 at a clock edge, the block SHALL clear pointers, occupancy, timestamp, event number and dropped to 0.
REQ-025 The cycle after reset, frame_pending SHALL be 0 and data SHALL be the idle frame with all-zero fields.
REQ-026 Reset asserted mid-readout SHALL discard all stored frames; a later sample_done SHALL be treated as on empty.
REQ-027 trig_valid and sample_done coincident with rst SHALL be ignored.

Structure
REQ-028 The frame field bit positions, HEADER and IDLE_HEADER defaults, and the 128-bit frame width SHALL be defined as constants in a shared package, opentrig_pkg, that is also used by the SPI readout stage.
REQ-029 Storage SHALL be one sub-module, frame_fifo: a synchronous DEPTH x 128 FIFO with push, pop, full, empty and show-ahead head output; frame assembly, counters and drop logic stay in the top level.

Verification
REQ-030 The bench SHALL cover: reset, then trig_valid with hits=64'h1 at timestamp 10 -> next cycle data={A5,00,0000,0000000A,0000000000000001} and frame_pending=1.
REQ-031 The bench SHALL cover: with DEPTH=4, 6 back-to-back triggers with no pop -> 4 frames stored, dropped=2, and the next accepted frame carries event number 6.
REQ-032 The bench SHALL cover: trig_valid and sample_done in the same cycle while full -> dropped unchanged, occupancy 4, head becomes event 1.
REQ-033 The bench SHALL cover: sample_done pulses with the buffer empty -> data remains the idle frame, frame_pending=0, pointers unchanged.
REQ-034 The bench SHALL cover: timestamp preset near 0xFFFFFFFF and event number near 0xFFFF -> stored values wrap to 0 correctly.
REQ-035 The bench SHALL cover: 3 frames stored, then rst mid-transfer -> frame_pending=0 and the idle frame follows; 300 forced drops -> dropped saturates at 8'hFF.

Source files
------------

// File: rtl/opentrig_pkg.sv
// Frame geometry and marker bytes shared by the event buffer and the SPI readout stage.
// Frames are 128 bits: header, dropped count, event number, timestamp, hit pattern (MSB to LSB).
package opentrig_pkg;

  localparam int FRAME_W  = 128;
  localparam int HITS_LSB = 0;
  localparam int HITS_W   = 64;
  localparam int TS_LSB   = 64;
  localparam int TS_W     = 32;
  localparam int EVT_LSB  = 96;
  localparam int EVT_W    = 16;
  localparam int DROP_LSB = 112;
  localparam int DROP_W   = 8;
  localparam int HDR_LSB  = 120;
  localparam int HDR_W    = 8;

  localparam logic [HDR_W-1:0] DEF_HEADER      = 8'hA5;
  localparam logic [HDR_W-1:0] DEF_IDLE_HEADER = 8'h5A;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [HDR_W-1:0]  hdr,
    input logic [DROP_W-1:0] drop,
    input logic [EVT_W-1:0]  evt,
    input logic [TS_W-1:0]   ts,
    input logic [HITS_W-1:0] hit_pat
  );
    logic [FRAME_W-1:0] f;
    f = '0;
    f[HDR_LSB  +: HDR_W]  = hdr;
    f[DROP_LSB +: DROP_W] = drop;
    f[EVT_LSB  +: EVT_W]  = evt;
    f[TS_LSB   +: TS_W]   = ts;
    f[HITS_LSB +: HITS_W] = hit_pat;
    return f;
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Synchronous DEPTH x 128 show-ahead frame FIFO; head_dat valid combinationally while !empty.
// Push while full is accepted only with a same-cycle pop; pop while empty is ignored.
module frame_fifo
  import opentrig_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     sampling_clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [FRAME_W-1:0]       push_dat,
  input  logic                     pop,
  output logic [FRAME_W-1:0]       head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FRAME_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // When full, push and pop share a slot: the head being popped is overwritten.
  always_ff @(posedge sampling_clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge sampling_clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/event_frame_buffer.sv
// Timestamps triggers into frames and queues them for SPI readout; new frame visible one cycle after an empty-buffer trigger.
// No backpressure on triggers: when full without a same-cycle pop the event is dropped and counted.
module event_frame_buffer
  import opentrig_pkg::*;
#(
  parameter int               DEPTH       = 4,
  parameter logic [HDR_W-1:0] HEADER      = DEF_HEADER,
  parameter logic [HDR_W-1:0] IDLE_HEADER = DEF_IDLE_HEADER
) (
  input  logic                sampling_clk,
  input  logic                rst,
  input  logic                trig_valid,
  input  logic [HITS_W-1:0]   hits,
  input  logic                sample_done,
  output logic [FRAME_W-1:0]  data,
  output logic                frame_pending,
  output logic [DROP_W-1:0]   dropped
);

  logic [TS_W-1:0]        timestamp;
  logic [TS_W-1:0]        last_pop_ts;
  logic [EVT_W-1:0]       event_num;
  logic [FRAME_W-1:0]     new_frame;
  logic [FRAME_W-1:0]     head;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] occ;
  logic                   pop;
  logic                   accept;
  logic                   drop;

  assign pop    = sample_done && !rst && !empty;
  assign accept = trig_valid && !rst && (!full || pop);
  assign drop   = trig_valid && !rst && full && !pop;

  assign new_frame = build_frame(HEADER, dropped, event_num, timestamp, hits);

  frame_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .sampling_clk (sampling_clk),
    .rst          (rst),
    .push         (accept),
    .push_dat     (new_frame),
    .pop          (pop),
    .head_dat     (head),
    .full         (full),
    .empty        (empty),
    .count        (occ)
  );

  always_ff @(posedge sampling_clk) begin
    if (rst) begin
      timestamp   <= '0;
      event_num   <= '0;
      dropped     <= '0;
      last_pop_ts <= '0;
    end else begin
      timestamp <= timestamp + TS_W'(1);
      if (trig_valid)                  event_num   <= event_num + EVT_W'(1);
      if (drop && (dropped != '1))     dropped     <= dropped + DROP_W'(1);
      if (pop)                         last_pop_ts <= timestamp;
    end
  end

  // Head only moves on pop or first push, so data holds steady across an SPI transfer.
  assign data          = empty ? build_frame(IDLE_HEADER, dropped, '0, last_pop_ts, '0) : head;
  assign frame_pending = (occ != '0);

endmodule

// File: tb/tb_event_frame_buffer.sv
// Directed bench for event_frame_buffer with a frame scoreboard and immediate-assertion checks.
module tb_event_frame_buffer;

  localparam int DEPTH = 4;

  logic         sampling_clk = 1'b0;
  logic         rst          = 1'b1;
  logic         trig_valid   = 1'b0;
  logic [63:0]  hits         = '0;
  logic         sample_done  = 1'b0;
  logic [127:0] data;
  logic         frame_pending;
  logic [7:0]   dropped;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [127:0] q[$];
  logic [31:0]  m_ts   = '0;
  logic [15:0]  m_evt  = '0;
  logic [7:0]   m_drop = '0;
  logic [31:0]  m_lpts = '0;

  event_frame_buffer #(
    .DEPTH       (DEPTH),
    .HEADER      (8'hA5),
    .IDLE_HEADER (8'h5A)
  ) dut (
    .sampling_clk  (sampling_clk),
    .rst           (rst),
    .trig_valid    (trig_valid),
    .hits          (hits),
    .sample_done   (sample_done),
    .data          (data),
    .frame_pending (frame_pending),
    .dropped       (dropped)
  );

  always #5 sampling_clk = ~sampling_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model, return #1 after the edge.
  task automatic cyc(input logic t, input logic [63:0] h, input logic d, input logic r);
    logic was_full;
    logic did_pop;
    trig_valid  = t;
    hits        = h;
    sample_done = d;
    rst         = r;
    if (r) begin
      q.delete();
      m_ts = '0; m_evt = '0; m_drop = '0; m_lpts = '0;
    end else begin
      was_full = (q.size() == DEPTH);
      did_pop  = d && (q.size() != 0);
      if (did_pop) begin
        void'(q.pop_front());
        m_lpts = m_ts;
      end
      if (t) begin
        if (!was_full || did_pop) q.push_back({8'hA5, m_drop, m_evt, m_ts, h});
        else if (m_drop != 8'hFF) m_drop++;
        m_evt++;
      end
      m_ts++;
    end
    @(posedge sampling_clk);
    #1;
    trig_valid  = 1'b0;
    sample_done = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [127:0] exp;
    exp = (q.size() != 0) ? q[0] : {8'h5A, m_drop, 16'h0, m_lpts, 64'h0};
    chk({tag, "_data"}, data, exp);
    chk({tag, "_pending"}, {127'h0, frame_pending}, {127'h0, q.size() != 0});
    chk({tag, "_dropped"}, {120'h0, dropped}, {120'h0, m_drop});
  endtask

  initial begin
    logic [127:0] f;
    // Reset and first-frame latency
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check_state("reset");
    chk("reset_idle_const", data, {8'h5A, 120'h0});
    repeat (10) cyc(0, 0, 0, 0);
    cyc(1, 64'h1, 0, 0);
    check_state("first_frame");
    chk("first_frame_const", data, 128'hA500_0000_0000_000A_0000_0000_0000_0001);

    // Pop to empty: idle frame carries last-pop timestamp
    cyc(0, 0, 1, 0);
    check_state("pop_to_idle");

    // Single frame with coincident trigger and pop
    cyc(1, 64'h22, 0, 0);
    cyc(1, 64'h33, 1, 0);
    check_state("one_frame_swap");
    chk("one_frame_swap_hits", {64'h0, data[63:0]}, {64'h0, 64'h33});
    cyc(0, 0, 1, 0);
    check_state("drain_swap");

    // Overflow: 6 triggers into DEPTH=4
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 64'h100 << i, 0, 0);
    check_state("overflow");
    chk("overflow_dropped", {120'h0, dropped}, {120'h0, 8'd2});
    chk("overflow_occ", {123'h0, dut.u_fifo.count}, 128'd4);

    // Full with coincident trigger and pop
    cyc(1, 64'hBEEF, 1, 0);
    check_state("full_swap");
    chk("full_swap_occ", {123'h0, dut.u_fifo.count}, 128'd4);
    chk("full_swap_head_evt", {112'h0, data[111:96]}, 128'd1);
    chk("full_swap_dropped", {120'h0, dropped}, {120'h0, 8'd2});
    for (int i = 0; i < 4; i++) begin
      f = data;
      cyc(0, 0, 1, 0);
      check_state($sformatf("drain%0d", i));
    end
    chk("last_evt6", {112'h0, f[111:96]}, 128'd6);

    // sample_done while empty
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0);
      check_state($sformatf("empty_done%0d", i));
      chk($sformatf("empty_occ%0d", i), {123'h0, dut.u_fifo.count}, 128'd0);
    end
    cyc(1, 64'h77, 0, 0);
    check_state("after_empty_done");
    cyc(0, 0, 1, 0);

    // Timestamp and event-number wrap
    cyc(0, 0, 0, 1);
    dut.timestamp = 32'hFFFF_FFFE;
    dut.event_num = 16'hFFFE;
    m_ts  = 32'hFFFF_FFFE;
    m_evt = 16'hFFFE;
    for (int i = 0; i < 3; i++) cyc(1, 64'hA0 + 64'(i), 0, 0);
    check_state("wrap0");
    chk("wrap0_ts", {96'h0, data[95:64]}, {96'h0, 32'hFFFF_FFFE});
    cyc(0, 0, 1, 0);
    check_state("wrap1");
    chk("wrap1_ts", {96'h0, data[95:64]}, {96'h0, 32'hFFFF_FFFF});
    chk("wrap1_evt", {112'h0, data[111:96]}, {112'h0, 16'hFFFF});
    cyc(0, 0, 1, 0);
    check_state("wrap2");
    chk("wrap2_ts", {96'h0, data[95:64]}, 128'd0);
    chk("wrap2_evt", {112'h0, data[111:96]}, 128'd0);
    cyc(0, 0, 1, 0);

    // Reset mid-transfer, with coincident trigger and sample_done
    for (int i = 0; i < 3; i++) cyc(1, 64'h5 << i, 0, 0);
    check_state("pre_rst");
    cyc(1, 64'hF, 1, 1);
    check_state("mid_rst");
    chk("mid_rst_idle_const", data, {8'h5A, 120'h0});
    cyc(0, 0, 1, 0);
    check_state("post_rst_done");
    chk("post_rst_occ", {123'h0, dut.u_fifo.count}, 128'd0);

    // Saturating drop counter
    for (int i = 0; i < DEPTH + 300; i++) cyc(1, 64'(i), 0, 0);
    check_state("saturate");
    chk("saturate_const", {120'h0, dropped}, {120'h0, 8'hFF});
    cyc(1, 64'h1234, 1, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 1, 0);
      check_state($sformatf("sat_drain%0d", i));
    end
    chk("sat_kept", {120'h0, dropped}, {120'h0, 8'hFF});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
